// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic HoldEnable   = 1'b1;
  localparam logic HoldDisable  = 1'b0;
  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;
  localparam logic [63:0] ZeroAddr = 64'h0;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'd0,
    JMP_DIRECT = 2'd1,
    JMP_REPLAY = 2'd2
  } jump_sel_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the EX stage, the stage registers and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int ADDR_W       = 32,
  parameter int NUM_STAGES   = 3,
  parameter int NUM_HOLD_SRC = 2,
  parameter int CNT_W        = 6
);
  logic                    jump_en_i;
  logic [ADDR_W-1:0]       jump_addr_i;
  logic [NUM_HOLD_SRC-1:0] hold_req_i;
  logic                    mc_start_i;
  logic [CNT_W-1:0]        mc_len_i;
  logic                    jump_en_o;
  logic [ADDR_W-1:0]       jump_addr_o;
  logic [NUM_STAGES-1:0]   stall_o;
  logic [NUM_STAGES-1:0]   flush_o;
  logic                    busy_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_req_i, mc_start_i, mc_len_i,
    input  jump_en_o, jump_addr_o, stall_o, flush_o, busy_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_req_i, mc_start_i, mc_len_i,
    output jump_en_o, jump_addr_o, stall_o, flush_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl_hold_cnt.sv
// Loadable down-counter timing multi-cycle holds; saturates at zero.
module hold_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_value,
  output logic             o_active
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value  = r_cnt;
  assign o_active = (r_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall/flush from jumps, level holds and timed
// multi-cycle holds; jumps arriving during a hold are captured and replayed.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int NUM_STAGES   = 3,
  parameter int NUM_HOLD_SRC = 2,
  parameter int CNT_W        = 6
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  logic [NUM_HOLD_SRC-1:0] w_hold_req;
  logic [CNT_W-1:0]        w_cnt;
  logic                    w_mc_act;
  logic                    w_mc_req;
  logic                    w_mc_load;
  logic                    w_hold_now;
  logic                    w_jump;
  logic                    w_defer;
  jump_sel_e               w_sel;

  logic                    r_pend_vld;
  logic [ADDR_W-1:0]       r_pend_addr;

  assign w_hold_req = bus.hold_req_i;

  // A start coinciding with a jump is dropped; the jump wins.
  assign w_mc_req  = bus.mc_start_i && (bus.mc_len_i != '0) && !bus.jump_en_i;
  assign w_mc_load = w_mc_req && (w_cnt == '0) && (bus.mc_len_i > CNT_W'(1));

  hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mc_load),
    .i_load_val (bus.mc_len_i - CNT_W'(1)),
    .o_value    (w_cnt),
    .o_active   (w_mc_act)
  );

  assign w_hold_now = (|w_hold_req) || w_mc_act || w_mc_req;

  always_comb begin
    w_sel = JMP_NONE;
    if (!w_hold_now) begin
      if (r_pend_vld) begin
        w_sel = JMP_REPLAY;
      end else if (bus.jump_en_i) begin
        w_sel = JMP_DIRECT;
      end
    end
  end

  assign w_jump  = (w_sel != JMP_NONE);
  assign w_defer = bus.jump_en_i && w_hold_now && !r_pend_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else if (w_sel == JMP_REPLAY) begin
      r_pend_vld  <= 1'b0;
    end else if (w_defer) begin
      r_pend_vld  <= 1'b1;
      r_pend_addr <= bus.jump_addr_i;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of inputs.
  assign bus.jump_en_o   = rst && w_jump;
  assign bus.jump_addr_o = !rst                ? ADDR_W'(ZeroAddr) :
                           (w_sel == JMP_REPLAY) ? r_pend_addr : bus.jump_addr_i;
  assign bus.busy_o      = rst && (w_mc_act || r_pend_vld);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign bus.stall_o[gi] = (rst && w_hold_now) ? HoldEnable : HoldDisable;
      if (gi == 0) begin : g_pc
        assign bus.flush_o[gi] = FlushDisable;
      end else begin : g_reg
        assign bus.flush_o[gi] = (rst && w_jump) ? FlushEnable : FlushDisable;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl plus a hand-written reset sequence.
module tb_pipe_ctrl;

  localparam int ADDR_W       = 32;
  localparam int NUM_STAGES   = 3;
  localparam int NUM_HOLD_SRC = 2;
  localparam int CNT_W        = 6;

  typedef struct {
    logic        je;
    logic [31:0] ja;
    logic [1:0]  hr;
    logic        ms;
    logic [5:0]  ml;
    logic        e_je;
    logic [31:0] e_ja;
    logic [2:0]  e_st;
    logic [2:0]  e_fl;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_ctrl_if #(
    .ADDR_W(ADDR_W), .NUM_STAGES(NUM_STAGES),
    .NUM_HOLD_SRC(NUM_HOLD_SRC), .CNT_W(CNT_W)
  ) bus ();

  pipe_ctrl #(
    .ADDR_W(ADDR_W), .NUM_STAGES(NUM_STAGES),
    .NUM_HOLD_SRC(NUM_HOLD_SRC), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic je, input logic [31:0] ja, input logic [1:0] hr,
                              input logic ms, input logic [5:0] ml, input logic e_je,
                              input logic [31:0] e_ja, input logic [2:0] e_st,
                              input logic [2:0] e_fl, input logic e_busy);
    vec_t v;
    v.je = je; v.ja = ja; v.hr = hr; v.ms = ms; v.ml = ml;
    v.e_je = e_je; v.e_ja = e_ja; v.e_st = e_st; v.e_fl = e_fl; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_je, input logic [31:0] e_ja,
                          input logic [2:0] e_st, input logic [2:0] e_fl, input logic e_busy);
    chk({tag, ".jump_en"},   32'(bus.jump_en_o), 32'(e_je));
    chk({tag, ".jump_addr"}, bus.jump_addr_o,    e_ja);
    chk({tag, ".stall"},     32'(bus.stall_o),   32'(e_st));
    chk({tag, ".flush"},     32'(bus.flush_o),   32'(e_fl));
    chk({tag, ".busy"},      32'(bus.busy_o),    32'(e_busy));
    $display("%s: je=%0b ja=0x%0h st=%b fl=%b busy=%0b", tag, bus.jump_en_o,
             bus.jump_addr_o, bus.stall_o, bus.flush_o, bus.busy_o);
  endtask

  task automatic drive(input logic je, input logic [31:0] ja, input logic [1:0] hr,
                       input logic ms, input logic [5:0] ml);
    bus.jump_en_i   = je;
    bus.jump_addr_i = ja;
    bus.hold_req_i  = hr;
    bus.mc_start_i  = ms;
    bus.mc_len_i    = ml;
  endtask

  initial begin
    // idle passthrough, then direct jump
    vecs.push_back(mk(0, 32'h1234, 2'b00, 0, 6'd0, 0, 32'h1234, 3'b000, 3'b000, 0));
    vecs.push_back(mk(1, 32'h0040, 2'b00, 0, 6'd0, 1, 32'h0040, 3'b000, 3'b110, 0));
    vecs.push_back(mk(0, 32'h0000, 2'b00, 0, 6'd0, 0, 32'h0000, 3'b000, 3'b000, 0));
    // multi-cycle hold L=5, then L=0 and L=1
    vecs.push_back(mk(0, 32'h0, 2'b00, 1, 6'd5, 0, 32'h0, 3'b111, 3'b000, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 32'h0, 2'b00, 0, 6'd0, 0, 32'h0, 3'b111, 3'b000, 1));
    vecs.push_back(mk(0, 32'h0, 2'b00, 0, 6'd0, 0, 32'h0, 3'b000, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0, 2'b00, 1, 6'd0, 0, 32'h0, 3'b000, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0, 2'b00, 0, 6'd0, 0, 32'h0, 3'b000, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0, 2'b00, 1, 6'd1, 0, 32'h0, 3'b111, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0, 2'b00, 0, 6'd0, 0, 32'h0, 3'b000, 3'b000, 0));
    // deferred jump under a level hold; later jump addresses must be ignored
    vecs.push_back(mk(0, 32'h000, 2'b01, 0, 6'd0, 0, 32'h000, 3'b111, 3'b000, 0));
    vecs.push_back(mk(1, 32'h100, 2'b01, 0, 6'd0, 0, 32'h100, 3'b111, 3'b000, 0));
    vecs.push_back(mk(1, 32'h300, 2'b01, 0, 6'd0, 0, 32'h300, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h100, 2'b01, 0, 6'd0, 0, 32'h100, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h200, 2'b00, 0, 6'd0, 1, 32'h100, 3'b000, 3'b110, 1));
    vecs.push_back(mk(0, 32'h000, 2'b00, 0, 6'd0, 0, 32'h000, 3'b000, 3'b000, 0));
    // overlap: mc L=3 + level hold 6 cycles, pending jump, second start (L=10) ignored
    vecs.push_back(mk(0, 32'h00, 2'b01, 1, 6'd3,  0, 32'h00, 3'b111, 3'b000, 0));
    vecs.push_back(mk(1, 32'h80, 2'b01, 1, 6'd10, 0, 32'h80, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h80, 2'b01, 0, 6'd0,  0, 32'h80, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h80, 2'b01, 0, 6'd0,  0, 32'h80, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h80, 2'b01, 0, 6'd0,  0, 32'h80, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h80, 2'b10, 0, 6'd0,  0, 32'h80, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h80, 2'b00, 0, 6'd0,  1, 32'h80, 3'b000, 3'b110, 1));
    vecs.push_back(mk(0, 32'h00, 2'b00, 0, 6'd0,  0, 32'h00, 3'b000, 3'b000, 0));
    // hold released exactly when the counter drains: replay in that cycle
    vecs.push_back(mk(0, 32'h000, 2'b01, 1, 6'd3, 0, 32'h000, 3'b111, 3'b000, 0));
    vecs.push_back(mk(1, 32'h500, 2'b01, 0, 6'd0, 0, 32'h500, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h500, 2'b01, 0, 6'd0, 0, 32'h500, 3'b111, 3'b000, 1));
    vecs.push_back(mk(1, 32'h600, 2'b00, 0, 6'd0, 1, 32'h500, 3'b000, 3'b110, 1));
    vecs.push_back(mk(0, 32'h000, 2'b00, 0, 6'd0, 0, 32'h000, 3'b000, 3'b000, 0));
    // jump beats a simultaneous multi-cycle start
    vecs.push_back(mk(1, 32'h44, 2'b00, 1, 6'd4, 1, 32'h44, 3'b000, 3'b110, 0));
    vecs.push_back(mk(0, 32'h00, 2'b00, 0, 6'd0, 0, 32'h00, 3'b000, 3'b000, 0));

    // reset state: requests active but outputs must stay quiet
    drive(1, 32'h55, 2'b11, 1, 6'd5);
    #2;
    chk_outs("reset", 0, 32'h0, 3'b000, 3'b000, 0);
    #6;
    rst = 1'b1;
    drive(0, 32'h0, 2'b00, 0, 6'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].je, vecs[i].ja, vecs[i].hr, vecs[i].ms, vecs[i].ml);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_je, vecs[i].e_ja, vecs[i].e_st,
               vecs[i].e_fl, vecs[i].e_busy);
    end

    // asynchronous reset mid multi-cycle hold with a jump pending
    @(posedge clk); #1;
    drive(0, 32'h0, 2'b00, 1, 6'd8);
    @(negedge clk);
    chk_outs("rstseq_start", 0, 32'h0, 3'b111, 3'b000, 0);
    @(posedge clk); #1;
    drive(1, 32'h700, 2'b00, 0, 6'd0);
    @(negedge clk);
    chk_outs("rstseq_defer", 0, 32'h700, 3'b111, 3'b000, 1);
    @(posedge clk); #1;
    drive(1, 32'h700, 2'b01, 0, 6'd0);
    @(negedge clk);
    chk_outs("rstseq_pend", 0, 32'h700, 3'b111, 3'b000, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_outs("rstseq_low", 0, 32'h0, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    chk_outs("rstseq_low_edge", 0, 32'h0, 3'b000, 3'b000, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    drive(0, 32'h900, 2'b00, 0, 6'd0);
    #1;
    chk_outs("rstseq_release", 0, 32'h900, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_outs("rstseq_idle", 0, 32'h900, 3'b000, 3'b000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit sitting between the EX stage and the stage registers (pc_reg, if_id, id_ex, …). It generates per-stage stall and flush vectors from a jump request, any number of level hold requests, and multi-cycle hold requests timed by an internal down-counter. A jump raised while the pipeline is held is captured and replayed when the hold releases, instead of being acted on immediately.

## Interface
Parameters:
- `ADDR_W`, 32, jump address width
- `NUM_STAGES`, 3, pipeline registers controlled; index 0 = pc, 1 = if_id, 2 = id_ex, …
- `NUM_HOLD_SRC`, 2, number of level hold request inputs
- `CNT_W`, 6, multi-cycle length width

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous reset, active-low
- `jump_en_i` in 1: jump request from EX
- `jump_addr_i` in ADDR_W: jump target
- `hold_req_i` in NUM_HOLD_SRC: level hold requests, any bit set holds the pipeline
- `mc_start_i` in 1: one-cycle pulse, starts a multi-cycle hold
- `mc_len_i` in CNT_W: multi-cycle hold length in cycles, sampled with `mc_start_i`
- `jump_en_o` out 1: load pc with `jump_addr_o`
- `jump_addr_o` out ADDR_W: jump target to pc_reg
- `stall_o` out NUM_STAGES: bit k set means stage register k keeps its value
- `flush_o` out NUM_STAGES: bit k set means stage register k loads a NOP; bit 0 is always 0
- `busy_o` out 1: multi-cycle hold active or jump pending

## Operation
- State: `cnt` (CNT_W), `mc_act` (cnt != 0), `pend_vld`, `pend_addr` (ADDR_W).
- `hold_now` = |hold_req_i, or mc_act, or (mc_start_i with mc_len_i != 0 and no jump_en_i).
- Stall: when hold_now is set, stall_o = all ones and flush_o = 0.
- Direct jump: jump_en_i, no hold_now, pend_vld = 0 -> jump_en_o = 1, jump_addr_o = jump_addr_i, flush_o[NUM_STAGES-1:1] all ones, stall_o = 0.
- Deferred jump: jump_en_i while hold_now and pend_vld = 0 -> pend_vld <= 1, pend_addr <= jump_addr_i. While pend_vld = 1, further jump_en_i is ignored; the held instruction re-presents it.
- Replay: first cycle with pend_vld = 1 and no hold_now -> jump_en_o = 1, jump_addr_o = pend_addr, flush as for a direct jump. pend_vld <= 0 at the next edge. jump_en_i in that same cycle is ignored.
- Multi-cycle hold: mc_start_i with L = mc_len_i gives a stall of exactly L cycles including the start cycle. cnt <= L-1 on start. L = 0 and L = 1 never set mc_act. cnt decrements each cycle while non-zero.
- mc_start_i while mc_act is already set: ignored, and cnt keeps counting. mc_start_i in the same cycle as jump_en_i: the jump has priority and the start is dropped.
- busy_o = mc_act | pend_vld.
- When no request is active, all outputs are 0 and jump_addr_o = jump_addr_i.

## Timing
- All outputs are combinational from inputs and registered state. Zero-cycle latency from a request to stall, flush or jump.
- Registered state updates on the rising clk edge.
- rst low asynchronously clears cnt, pend_vld and pend_addr. While rst is low: jump_en_o = 0, stall_o = 0, flush_o = 0, busy_o = 0, jump_addr_o = 0.
- Reset mid multi-cycle hold or with a jump pending discards both. The first cycle after release behaves as idle.
- hold_req_i released in the same cycle cnt reaches 0 means the replay happens that same cycle.
- cnt never wraps: decrement only when non-zero.

## Structure
- defines.v gains `HoldEnable`/`HoldDisable` (reuse existing), `FlushEnable`/`FlushDisable` and `ZeroAddr`.
- Sub-module `hold_cnt` holds the loadable down-counter (CNT_W, load, value, active flag). Everything else stays in pipe_ctrl.

## Test plan
- Direct jump: idle, jump_en_i = 1, jump_addr_i = 0x0000_0040 -> same cycle jump_en_o = 1, addr 0x40, flush_o = 3'b110, stall_o = 0; idle the next cycle.
- Multi-cycle hold: mc_start_i with mc_len_i = 5 -> stall_o = 3'b111 for exactly 5 cycles, busy_o for 4 cycles after the start, then idle. mc_len_i = 0 -> no stall.
- Deferred jump: hold_req_i = 2'b01 for 4 cycles, jump_en_i = 1 to 0x100 from cycle 1 onward -> no jump_en_o while held, stall_o = 3'b111. On release: jump_en_o = 1 with addr 0x100 and flush_o = 3'b110 for exactly one cycle.
- Overlap: mc_start_i with mc_len_i = 3 plus hold_req_i held 6 cycles, a jump pending, and a second mc_start_i at cycle 1 -> stall for 6 cycles, the second start ignored, replay in cycle 6.
- Priority: mc_start_i and jump_en_i in the same cycle -> direct jump, no stall, busy_o = 0 the next cycle.
- Reset: rst low during a multi-cycle hold with a jump pending -> all outputs 0 immediately. After release, no replay and no stall.
